pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and instruction-holding stage of the multi-cycle MIPS core. It sits directly downstream of the main control FSM and consumes `PCWrite`, `BranchEq`, `BranchNotEq`, `PCsource` and `InstrLatch`. It owns the PC, instruction and ALU-result registers, resolves branch and jump targets, and feeds `opField` back to the FSM. It also provides sticky error flags and instruction / taken-branch performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 32: width of both performance counters.

Ports:
- `clk` in 1: core clock; all registers update on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `PCWrite` in 1: unconditional PC write enable from the FSM.
- `BranchEq` in 1: beq-cycle qualifier.
- `BranchNotEq` in 1: bne-cycle qualifier.
- `PCsource` in 2: next-PC select. 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = reserved.
- `InstrLatch` in 1: capture MemRdata into the instruction register.
- `ALUResult` in 32: combinational ALU output.
- `Zero` in 1: ALU zero flag.
- `MemRdata` in 32: registered memory read data.
- `CntClear` in 1: synchronous clear of both counters.
- `PC` out 32: current PC register.
- `Instr` out 32: instruction register.
- `opField` out 6: opcode presented to the FSM.
- `ALUOut` out 32: ALU result registered every cycle.
- `LinkPC` out 32: return address for jal.
- `InstrCount` out CNT_W: number of latched instructions.
- `BranchTakenCount` out CNT_W: number of taken beq/bne.
- `AlignErr` out 1: sticky; set when a PC with nonzero bits [1:0] is written.
- `SelErr` out 1: sticky; set when a PC write is requested with PCsource = 11.

## Operation
- **Reset values:** PC = RESET_PC. Instr, ALUOut, both counters, AlignErr and SelErr are 0.
- **ALUOut:** loads ALUResult every cycle with no enable. The branch target computed during Decode is held in ALUOut through the Branch cycle.
- **Branch condition:** taken = (BranchEq & Zero) | (BranchNotEq & ~Zero).
- **PC enable:** PCEn = PCWrite | taken.
- **Next-PC selection:**
  - 00: ALUResult (PC+4 during Fetch).
  - 01: ALUOut.
  - 10: {PC[31:28], Instr[25:0], 2'b00}.
  - 11: PC is held, and SelErr is set if PCEn = 1.
- **Alignment:** when PC is loaded with a value whose bits [1:0] ≠ 0, PC is still loaded and AlignErr is set.
- **Instruction register:** loads MemRdata when InstrLatch = 1; otherwise it holds.
- **opField bypass:** opField = InstrLatch ? MemRdata[31:26] : Instr[31:26]. This bypass lets the FSM decode in the same cycle the instruction is latched.
- **LinkPC:** equals PC. By the Link state, PC has already advanced to the return address (old PC+4).
- **InstrCount:** increments by 1 on every cycle with InstrLatch = 1.
- **BranchTakenCount:** increments by 1 on every cycle with taken = 1.
- **Counter wrap:** both counters wrap modulo 2^CNT_W.
- **CntClear:** has priority over an increment in the same cycle; the counter becomes 0.
- **Simultaneous PCWrite and taken:** a single PC load using PCsource; BranchTakenCount still increments.
- **Error flags:** AlignErr and SelErr clear only on reset.

## Timing
- PC, Instr, ALUOut, counters and flags are registered and visible one cycle after the enabling condition.
- opField, LinkPC and the taken/PCEn terms are combinational, with zero latency.
- **Fetch:** PC becomes old PC+4 at the end of the Fetch cycle.
- **Decode:** Instr is valid from the cycle after Decode. The branch target is in ALUOut from the cycle after Decode.
- **Branch:** a taken branch updates PC at the end of the Branch cycle. A not-taken branch leaves PC unchanged.
- **Mid-operation reset:** reset asserted at any point asynchronously forces all reset values. The first rising edge after deassertion behaves as a normal Fetch.

## Structure
- **Shared package `mips_pkg`:**
  - `pcsrc_t` enum: PCSRC_PLUS4 = 2'b00, PCSRC_BRANCH = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_RSVD = 2'b11.
  - Opcode constants (lw, sw, R-type, beq, bne, addi, j, jal), shared with the FSM.
- **Sub-module `pc_next_sel`:** combinational; computes taken, PCEn, the next-PC value and the illegal-select term.
- Registers and counters stay in `pc_unit`.

## Test plan
- **Reset:** assert reset mid-cycle, with RESET_PC = 32'h0000_0040. PC = 0x40, Instr = 0, counters = 0 and flags = 0 immediately, before any clock edge.
- **Fetch/decode:** PC = 0x0; Fetch cycle with ALUResult = 0x4; Decode cycle with MemRdata = 0x8C08_0004 (lw). PC = 0x4; opField = 6'b100011 during Decode; Instr = 0x8C08_0004 after; InstrCount = 1.
- **beq taken/not taken:** ALUOut = 0x20. Branch cycle with BranchEq = 1, Zero = 1 gives PC = 0x20 and BranchTakenCount = 1. Repeat with Zero = 0: PC is unchanged and the count is unchanged.
- **bne and jump:**
  - bne with Zero = 0 loads ALUOut into PC.
  - jump with PC = 0x1000_0008, Instr = 0x0800_0010, PCsource = 10 gives PC = 0x1000_0040.
  - LinkPC equals PC during the Link cycle.
- **Errors:**
  - PCWrite = 1 with PCsource = 11 holds PC and sets SelErr.
  - PCWrite = 1 with ALUResult = 0x6 gives PC = 0x6 and sets AlignErr.
  - Both flags persist until reset.
- **Counters:** preload InstrCount to all-ones (CNT_W = 4, value 15).
  - InstrLatch gives 0 (wrap).
  - CntClear together with InstrLatch gives 0.
  - CntClear together with a taken branch gives BranchTakenCount = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: next-PC select encoding
// and primary opcodes decoded by the control FSM.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC resolution: branch condition, PC write enable,
// target mux and detection of a write through the reserved select.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic        pcWrite_i,
  input  logic        branchEq_i,
  input  logic        branchNotEq_i,
  input  logic        zero_i,
  input  pcsrc_t      pcSrc_i,
  input  logic [31:0] aluResult_i,
  input  logic [31:0] aluOut_i,
  input  logic [31:0] pc_i,
  input  logic [25:0] jumpIdx_i,
  output logic        taken_o,
  output logic        pcEn_o,
  output logic        pcLoad_o,
  output logic [31:0] nextPc_o,
  output logic        selErr_o
);

  always_comb begin
    taken_o  = (branchEq_i & zero_i) | (branchNotEq_i & ~zero_i);
    pcEn_o   = pcWrite_i | taken_o;
    nextPc_o = pc_i;
    case (pcSrc_i)
      PCSRC_PLUS4:  nextPc_o = aluResult_i;
      PCSRC_BRANCH: nextPc_o = aluOut_i;
      PCSRC_JUMP:   nextPc_o = {pc_i[31:28], jumpIdx_i, 2'b00};
      default:      nextPc_o = pc_i;
    endcase
    // The reserved select never loads the PC; it only flags the attempt.
    pcLoad_o = pcEn_o & (pcSrc_i != PCSRC_RSVD);
    selErr_o = pcEn_o & (pcSrc_i == PCSRC_RSVD);
  end

endmodule

// File: rtl/pc_unit.sv
// PC / instruction / ALU-result holding stage of the multi-cycle MIPS core,
// with sticky PC error flags and instruction / taken-branch counters.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             BranchEq,
  input  logic             BranchNotEq,
  input  logic [1:0]       PCsource,
  input  logic             InstrLatch,
  input  logic [31:0]      ALUResult,
  input  logic             Zero,
  input  logic [31:0]      MemRdata,
  input  logic             CntClear,
  output logic [31:0]      PC,
  output logic [31:0]      Instr,
  output logic [5:0]       opField,
  output logic [31:0]      ALUOut,
  output logic [31:0]      LinkPC,
  output logic [CNT_W-1:0] InstrCount,
  output logic [CNT_W-1:0] BranchTakenCount,
  output logic             AlignErr,
  output logic             SelErr
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      aluOut_q;
  logic [CNT_W-1:0] instrCnt_q, instrCnt_d;
  logic [CNT_W-1:0] brCnt_q, brCnt_d;
  logic             alignErr_q, alignErr_d;
  logic             selErr_q, selErr_d;

  logic        taken;
  logic        pcEn;
  logic        pcLoad;
  logic [31:0] nextPc;
  logic        selIllegal;

  pc_next_sel u_next_sel (
    .pcWrite_i     (PCWrite),
    .branchEq_i    (BranchEq),
    .branchNotEq_i (BranchNotEq),
    .zero_i        (Zero),
    .pcSrc_i       (pcsrc_t'(PCsource)),
    .aluResult_i   (ALUResult),
    .aluOut_i      (aluOut_q),
    .pc_i          (pc_q),
    .jumpIdx_i     (instr_q[25:0]),
    .taken_o       (taken),
    .pcEn_o        (pcEn),
    .pcLoad_o      (pcLoad),
    .nextPc_o      (nextPc),
    .selErr_o      (selIllegal)
  );

  always_comb begin
    pc_d       = pcLoad ? nextPc : pc_q;
    alignErr_d = alignErr_q | (pcLoad & (nextPc[1:0] != 2'b00));
    selErr_d   = selErr_q | selIllegal;
    instr_d    = InstrLatch ? MemRdata : instr_q;
    // Clear wins over a same-cycle increment.
    instrCnt_d = instrCnt_q;
    if (CntClear)        instrCnt_d = '0;
    else if (InstrLatch) instrCnt_d = instrCnt_q + CNT_W'(1);
    brCnt_d = brCnt_q;
    if (CntClear)   brCnt_d = '0;
    else if (taken) brCnt_d = brCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      aluOut_q   <= '0;
      instrCnt_q <= '0;
      brCnt_q    <= '0;
      alignErr_q <= 1'b0;
      selErr_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      aluOut_q   <= ALUResult;
      instrCnt_q <= instrCnt_d;
      brCnt_q    <= brCnt_d;
      alignErr_q <= alignErr_d;
      selErr_q   <= selErr_d;
    end
  end

  // Decode-cycle bypass so the FSM sees the opcode as it is being latched.
  assign opField          = InstrLatch ? MemRdata[31:26] : instr_q[31:26];
  assign PC               = pc_q;
  assign LinkPC           = pc_q;
  assign Instr            = instr_q;
  assign ALUOut           = aluOut_q;
  assign InstrCount       = instrCnt_q;
  assign BranchTakenCount = brCnt_q;
  assign AlignErr         = alignErr_q;
  assign SelErr           = selErr_q;

  logic unusedPcEn;
  assign unusedPcEn = pcEn;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (RESET_PC = 0x40, 4-bit counters) with
// hand-computed expected values.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        PCWrite, BranchEq, BranchNotEq, InstrLatch, Zero, CntClear;
  logic [1:0]  PCsource;
  logic [31:0] ALUResult, MemRdata;
  logic [31:0] PC, Instr, ALUOut, LinkPC;
  logic [5:0]  opField;
  logic [3:0]  InstrCount, BranchTakenCount;
  logic        AlignErr, SelErr;

  int vectorCount = 0;
  int missCount   = 0;

  pc_unit #(.RESET_PC(32'h0000_0040), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .BranchEq(BranchEq),
    .BranchNotEq(BranchNotEq), .PCsource(PCsource), .InstrLatch(InstrLatch),
    .ALUResult(ALUResult), .Zero(Zero), .MemRdata(MemRdata), .CntClear(CntClear),
    .PC(PC), .Instr(Instr), .opField(opField), .ALUOut(ALUOut), .LinkPC(LinkPC),
    .InstrCount(InstrCount), .BranchTakenCount(BranchTakenCount),
    .AlignErr(AlignErr), .SelErr(SelErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Inputs: pcWrite, beq, bne, pcSrc, latch, aluResult, zero, memRdata, clear.
  task automatic applyStimulus(input logic pw, input logic be, input logic bn,
                               input logic [1:0] src, input logic il,
                               input logic [31:0] alur, input logic z,
                               input logic [31:0] mem, input logic clr);
    PCWrite = pw; BranchEq = be; BranchNotEq = bn; PCsource = src;
    InstrLatch = il; ALUResult = alur; Zero = z; MemRdata = mem; CntClear = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0);
    #2;
    checkOutput("rst_pc", PC, 32'h40);
    checkOutput("rst_instr", Instr, 32'h0);
    checkOutput("rst_icnt", {28'h0, InstrCount}, 32'h0);
    checkOutput("rst_flags", {30'h0, AlignErr, SelErr}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Bring PC to 0, then Fetch to PC+4.
    applyStimulus(1, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0); tick();
    checkOutput("pc_zero", PC, 32'h0);
    applyStimulus(1, 0, 0, 2'b00, 0, 32'h4, 0, 32'h0, 0); tick();
    checkOutput("fetch_pc", PC, 32'h4);

    // Decode: latch lw, branch target 0x20 into ALUOut.
    applyStimulus(0, 0, 0, 2'b00, 1, 32'h20, 0, 32'h8C08_0004, 0);
    checkOutput("op_bypass", {26'h0, opField}, 32'h23);
    tick();
    checkOutput("instr", Instr, 32'h8C08_0004);
    checkOutput("icnt1", {28'h0, InstrCount}, 32'h1);
    checkOutput("aluout", ALUOut, 32'h20);
    checkOutput("pc_hold", PC, 32'h4);

    // beq taken.
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("op_reg", {26'h0, opField}, 32'h23);
    tick();
    checkOutput("beq_pc", PC, 32'h20);
    checkOutput("beq_cnt", {28'h0, BranchTakenCount}, 32'h1);

    // beq not taken.
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h88, 0, 32'h0, 0); tick();
    checkOutput("beqnt_pc", PC, 32'h20);
    checkOutput("beqnt_cnt", {28'h0, BranchTakenCount}, 32'h1);

    // bne taken: ALUOut now 0x88.
    applyStimulus(0, 0, 1, 2'b01, 0, 32'h0, 0, 32'h0, 0); tick();
    checkOutput("bne_pc", PC, 32'h88);
    checkOutput("bne_cnt", {28'h0, BranchTakenCount}, 32'h2);

    // Jump: load PC and Instr, then select jump target.
    applyStimulus(1, 0, 0, 2'b00, 1, 32'h1000_0008, 0, 32'h0800_0010, 0); tick();
    checkOutput("jpre_pc", PC, 32'h1000_0008);
    applyStimulus(1, 0, 0, 2'b10, 0, 32'h0, 0, 32'h0, 0); tick();
    checkOutput("jump_pc", PC, 32'h1000_0040);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("linkpc", LinkPC, 32'h1000_0040);

    // PCWrite together with a taken branch.
    applyStimulus(1, 1, 0, 2'b00, 0, 32'h100, 1, 32'h0, 0); tick();
    checkOutput("both_pc", PC, 32'h100);
    checkOutput("both_cnt", {28'h0, BranchTakenCount}, 32'h3);

    // Reserved select.
    applyStimulus(1, 0, 0, 2'b11, 0, 32'h200, 0, 32'h0, 0); tick();
    checkOutput("sel_pc", PC, 32'h100);
    checkOutput("sel_flags", {30'h0, AlignErr, SelErr}, 32'h1);

    // Misaligned write.
    applyStimulus(1, 0, 0, 2'b00, 0, 32'h6, 0, 32'h0, 0); tick();
    checkOutput("align_pc", PC, 32'h6);
    checkOutput("align_flags", {30'h0, AlignErr, SelErr}, 32'h3);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0); tick(); tick();
    checkOutput("sticky_flags", {30'h0, AlignErr, SelErr}, 32'h3);

    // Counters: InstrCount is 2, take it to 15 then wrap.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 1, 32'h0, 0, 32'h1234_0000 + i, 0); tick();
    end
    checkOutput("icnt_max", {28'h0, InstrCount}, 32'hF);
    applyStimulus(0, 0, 0, 2'b00, 1, 32'h0, 0, 32'h0, 0); tick();
    checkOutput("icnt_wrap", {28'h0, InstrCount}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 1, 32'h0, 0, 32'h0, 0); tick();
    end
    checkOutput("icnt_three", {28'h0, InstrCount}, 32'h3);
    applyStimulus(0, 0, 0, 2'b00, 1, 32'h0, 0, 32'h0, 1); tick();
    checkOutput("icnt_clr", {28'h0, InstrCount}, 32'h0);
    checkOutput("bcnt_clr", {28'h0, BranchTakenCount}, 32'h0);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h0, 1, 32'h0, 0); tick();
    checkOutput("bcnt_one", {28'h0, BranchTakenCount}, 32'h1);
    applyStimulus(0, 1, 0, 2'b01, 0, 32'h0, 1, 32'h0, 1); tick();
    checkOutput("bcnt_clr_taken", {28'h0, BranchTakenCount}, 32'h0);
    checkOutput("sticky_flags2", {30'h0, AlignErr, SelErr}, 32'h3);

    // Mid-cycle asynchronous reset.
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_pc", PC, 32'h40);
    checkOutput("mid_instr", Instr, 32'h0);
    checkOutput("mid_aluout", ALUOut, 32'h0);
    checkOutput("mid_cnts", {24'h0, InstrCount, BranchTakenCount}, 32'h0);
    checkOutput("mid_flags", {30'h0, AlignErr, SelErr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 2'b00, 0, 32'h44, 0, 32'h0, 0); tick();
    checkOutput("post_fetch", PC, 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
